// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and registered ALU-operand outputs of alu_input_loader.
// master: the side driving the board inputs; slave: the loader itself.
interface alu_input_loader_if #(
   parameter int unsigned NB_DATA   = 8,
   parameter int unsigned NB_OPCODE = 6
) ();

   logic [NB_DATA-1:0]   i_sw;
   logic                 i_btn_a;
   logic                 i_btn_b;
   logic                 i_btn_op;
   logic [NB_DATA-1:0]   o_op_1;
   logic [NB_DATA-1:0]   o_op_2;
   logic [NB_OPCODE-1:0] o_opcode;
   logic                 o_update;
   logic                 o_op_err;

   modport master (
      output i_sw, i_btn_a, i_btn_b, i_btn_op,
      input  o_op_1, o_op_2, o_opcode, o_update, o_op_err
   );

   modport slave (
      input  i_sw, i_btn_a, i_btn_b, i_btn_op,
      output o_op_1, o_op_2, o_opcode, o_update, o_op_err
   );

endinterface

// File: rtl/alu_input_loader.sv
// Debounces three push-buttons and latches the switch value into ALU operand A,
// operand B or a validated opcode, pulsing o_update / o_op_err on each press.
module alu_input_loader #(
   parameter int unsigned NB_DATA         = 8,
   parameter int unsigned NB_OPCODE       = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned NB_DEB_CNT      = 20
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   alu_input_loader_if.slave bus
);

   localparam int unsigned NB_CH = 3;
   localparam int unsigned CH_A  = 0;
   localparam int unsigned CH_B  = 1;
   localparam int unsigned CH_OP = 2;

   localparam logic [NB_DEB_CNT-1:0] DEB_LAST = NB_DEB_CNT'(DEBOUNCE_CYCLES - 1);

   localparam logic [NB_OPCODE-1:0] OPC_ADD = NB_OPCODE'(6'b100000);
   localparam logic [NB_OPCODE-1:0] OPC_SUB = NB_OPCODE'(6'b100010);
   localparam logic [NB_OPCODE-1:0] OPC_AND = NB_OPCODE'(6'b100100);
   localparam logic [NB_OPCODE-1:0] OPC_OR  = NB_OPCODE'(6'b100101);
   localparam logic [NB_OPCODE-1:0] OPC_XOR = NB_OPCODE'(6'b100110);
   localparam logic [NB_OPCODE-1:0] OPC_SRA = NB_OPCODE'(6'b000011);
   localparam logic [NB_OPCODE-1:0] OPC_SRL = NB_OPCODE'(6'b000010);
   localparam logic [NB_OPCODE-1:0] OPC_NOR = NB_OPCODE'(6'b100111);

   function automatic logic opcode_valid(input logic [NB_OPCODE-1:0] op);
      case (op)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
         OPC_XOR, OPC_SRA, OPC_SRL, OPC_NOR: opcode_valid = 1'b1;
         default:                            opcode_valid = 1'b0;
      endcase
   endfunction

   logic [NB_CH-1:0]      btn_raw_c;
   logic [NB_CH-1:0]      sync1_q;
   logic [NB_CH-1:0]      sync2_q;
   logic [NB_CH-1:0]      deb_q;
   logic [NB_CH-1:0]      deb_d;
   logic [NB_CH-1:0]      deb_dly_q;
   logic [NB_CH-1:0]      press_c;
   logic [NB_DEB_CNT-1:0] cnt_q [NB_CH];
   logic [NB_DEB_CNT-1:0] cnt_d [NB_CH];

   logic [NB_DATA-1:0]    op_1_q, op_1_d;
   logic [NB_DATA-1:0]    op_2_q, op_2_d;
   logic [NB_OPCODE-1:0]  opcode_q, opcode_d;
   logic                  update_q, update_d;
   logic                  op_err_q, op_err_d;
   logic [NB_OPCODE-1:0]  sw_opcode_c;

   assign btn_raw_c   = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};
   assign sw_opcode_c = bus.i_sw[NB_OPCODE-1:0];
   // A press is the debounced level rising; holding the button adds nothing.
   assign press_c     = deb_q & ~deb_dly_q;

   // Debouncer: the level only follows after DEBOUNCE_CYCLES differing cycles in a row.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int unsigned ch = 0; ch < NB_CH; ch++) begin
         cnt_d[ch] = '0;
         if (sync2_q[ch] != deb_q[ch]) begin
            if (cnt_q[ch] == DEB_LAST) begin
               deb_d[ch] = sync2_q[ch];
            end else begin
               cnt_d[ch] = cnt_q[ch] + NB_DEB_CNT'(1);
            end
         end
      end
   end

   // Register loads; all pressed channels share the same switch sample.
   always_comb begin
      op_1_d   = op_1_q;
      op_2_d   = op_2_q;
      opcode_d = opcode_q;
      update_d = 1'b0;
      op_err_d = 1'b0;
      if (press_c[CH_A]) begin
         op_1_d   = bus.i_sw;
         update_d = 1'b1;
      end
      if (press_c[CH_B]) begin
         op_2_d   = bus.i_sw;
         update_d = 1'b1;
      end
      if (press_c[CH_OP]) begin
         if (opcode_valid(sw_opcode_c)) begin
            opcode_d = sw_opcode_c;
            update_d = 1'b1;
         end else begin
            op_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int unsigned ch = 0; ch < NB_CH; ch++) begin
            cnt_q[ch] <= '0;
         end
         op_1_q    <= '0;
         op_2_q    <= '0;
         opcode_q  <= OPC_ADD;
         update_q  <= 1'b0;
         op_err_q  <= 1'b0;
      end else begin
         sync1_q   <= btn_raw_c;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         cnt_q     <= cnt_d;
         op_1_q    <= op_1_d;
         op_2_q    <= op_2_d;
         opcode_q  <= opcode_d;
         update_q  <= update_d;
         op_err_q  <= op_err_d;
      end
   end

   assign bus.o_op_1   = op_1_q;
   assign bus.o_op_2   = op_2_q;
   assign bus.o_opcode = opcode_q;
   assign bus.o_update = update_q;
   assign bus.o_op_err = op_err_q;

endmodule
